// File: rtl/ppc_pkg.sv
// Shared PPC core definitions: load/store op encodings, exception causes,
// LSU FSM state and small op-classification helpers.
package ppc_pkg;

  localparam logic [2:0] LSU_LD   = 3'd0;
  localparam logic [2:0] LSU_LDU  = 3'd1;
  localparam logic [2:0] LSU_LWZ  = 3'd2;
  localparam logic [2:0] LSU_LWZU = 3'd3;
  localparam logic [2:0] LSU_STD  = 3'd4;
  localparam logic [2:0] LSU_STDU = 3'd5;

  localparam logic [1:0] EXC_NONE    = 2'd0;
  localparam logic [1:0] EXC_ALIGN   = 2'd1;
  localparam logic [1:0] EXC_TIMEOUT = 2'd2;
  localparam logic [1:0] EXC_FORM    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } lsu_state_t;

  function automatic logic lsu_is_update(input logic [2:0] op);
    return (op == LSU_LDU) || (op == LSU_LWZU) || (op == LSU_STDU);
  endfunction

  function automatic logic lsu_is_store(input logic [2:0] op);
    return (op == LSU_STD) || (op == LSU_STDU);
  endfunction

  function automatic logic lsu_is_word(input logic [2:0] op);
    return (op == LSU_LWZ) || (op == LSU_LWZU);
  endfunction

endpackage

// File: rtl/ppc_lsu_check.sv
// Combinational illegal-form and alignment check for one load/store op;
// shared with decode so it can trap early.
module ppc_lsu_check
  import ppc_pkg::*;
(
  input  logic [2:0] i_op,
  input  logic [2:0] i_ea_lo,   // low three EA bits (big-endian ea[61:63])
  input  logic [4:0] i_rt,
  input  logic [4:0] i_ra,
  output logic       o_exc,
  output logic [1:0] o_cause
);

  logic w_illegal;
  logic w_misalign;

  assign w_illegal = (i_op > LSU_STDU)
                   | (lsu_is_update(i_op) & (i_ra == 5'd0))
                   | (((i_op == LSU_LDU) | (i_op == LSU_LWZU)) & (i_ra == i_rt));

  assign w_misalign = lsu_is_word(i_op) ? (|i_ea_lo[1:0]) : (|i_ea_lo);

  // Form errors outrank alignment so a bad encoding never reports cause 1.
  assign o_exc   = w_illegal | w_misalign;
  assign o_cause = w_illegal  ? EXC_FORM  :
                   w_misalign ? EXC_ALIGN : EXC_NONE;

endmodule

// File: rtl/ppc_lsu.sv
// Multi-cycle PPC load/store unit: decode handshake, variable-latency memory
// port, GPR writeback for rt and ra, and alignment/form/timeout exceptions.
module ppc_lsu
  import ppc_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int MEM_AW  = 61,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [XLEN-1:0]   req_ea,
  input  logic [XLEN-1:0]   req_sdata,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_ra,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              wb_valid,
  output logic              wb_rt_we,
  output logic [4:0]        wb_rt,
  output logic [XLEN-1:0]   wb_rt_data,
  output logic              wb_ra_we,
  output logic [4:0]        wb_ra,
  output logic [XLEN-1:0]   wb_ra_data,
  output logic              exc_valid,
  output logic [1:0]        exc_cause,
  output logic              busy
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  lsu_state_t      r_state;
  lsu_state_t      w_next;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_ea;
  logic [XLEN-1:0] r_sdata;
  logic [4:0]      r_rt;
  logic [4:0]      r_ra;
  logic [XLEN-1:0] r_rdata;
  logic [CW-1:0]   r_cnt;

  logic            w_accept;
  logic            w_chk_exc;
  logic [1:0]      w_chk_cause;
  logic            w_timeout;
  logic            w_store;
  logic            w_done;
  logic [31:0]     w_word;

  ppc_lsu_check u_check (
    .i_op    (r_op),
    .i_ea_lo (r_ea[2:0]),
    .i_rt    (r_rt),
    .i_ra    (r_ra),
    .o_exc   (w_chk_exc),
    .o_cause (w_chk_cause)
  );

  assign w_accept  = req_valid & req_ready;
  assign w_store   = lsu_is_store(r_op);
  assign w_done    = (r_state == ST_DONE);
  // A response arriving on the last allowed cycle still wins over the timeout.
  assign w_timeout = (r_state == ST_WAIT) & ~mem_rvalid & (r_cnt == CW'(TIMEOUT - 1));
  // Big-endian ea[61]=0 picks rdata[0:31], i.e. the upper 32 bits here.
  assign w_word    = r_ea[2] ? mem_rdata[31:0] : mem_rdata[63:32];

  // NOTE: w_next gets a default before the case so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (req_valid) w_next = ST_CHECK;
      ST_CHECK: w_next = w_chk_exc ? ST_IDLE : ST_REQ;
      ST_REQ:   if (mem_ready) w_next = w_store ? ST_DONE : ST_WAIT;
      ST_WAIT: begin
        if (mem_rvalid)     w_next = ST_DONE;
        else if (w_timeout) w_next = ST_DRAIN;
      end
      ST_DRAIN: if (mem_rvalid) w_next = ST_IDLE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= '0;
      r_ea    <= '0;
      r_sdata <= '0;
      r_rt    <= '0;
      r_ra    <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= req_op;
        r_ea    <= req_ea;
        r_sdata <= req_sdata;
        r_rt    <= req_rt;
        r_ra    <= req_ra;
      end
      if ((r_state == ST_REQ) && mem_ready) r_cnt <= '0;
      else if (r_state == ST_WAIT)          r_cnt <= r_cnt + CW'(1);
      if ((r_state == ST_WAIT) && mem_rvalid)
        r_rdata <= lsu_is_word(r_op) ? {{(XLEN-32){1'b0}}, w_word} : mem_rdata;
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);

  assign mem_valid  = (r_state == ST_REQ);
  assign mem_addr   = mem_valid ? r_ea[XLEN-1 -: MEM_AW] : '0;
  assign mem_we     = mem_valid & w_store;
  assign mem_wdata  = mem_we ? r_sdata : '0;

  assign wb_valid   = w_done;
  assign wb_rt_we   = w_done & ~w_store;
  assign wb_rt      = wb_rt_we ? r_rt : '0;
  assign wb_rt_data = wb_rt_we ? r_rdata : '0;
  assign wb_ra_we   = w_done & lsu_is_update(r_op);
  assign wb_ra      = wb_ra_we ? r_ra : '0;
  assign wb_ra_data = wb_ra_we ? r_ea : '0;

  assign exc_valid  = ((r_state == ST_CHECK) & w_chk_exc) | w_timeout;
  assign exc_cause  = (r_state == ST_CHECK) ? w_chk_cause :
                      w_timeout             ? EXC_TIMEOUT : EXC_NONE;

endmodule

// File: doc/ppc_lsu.md
Name: ppc_lsu

Overview:
- Multi-cycle load/store unit for the PPC core; replaces the single-cycle combinational ld/ldu path.
- Accepts one memory op from decode over a valid/ready handshake.
- Drives a handshaked memory port that tolerates variable latency.
- Returns GPR writebacks for rt and, on update forms, for ra.
- Adds stores, word loads, alignment checking, illegal-form detection and a response timeout.

Parameters:
- XLEN, 64, datapath and effective-address width; only 64 is supported.
- MEM_AW, 61, memory doubleword address width, equal to XLEN-3.
- TIMEOUT, 255, maximum cycles in WAIT for mem_rvalid before a timeout exception; must be at least 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  decode presents an op
- req_ready  out  1  unit can accept; high only in IDLE
- req_op  in  3  0=LD 1=LDU 2=LWZ 3=LWZU 4=STD 5=STDU; 6 and 7 are illegal
- req_ea  in  64  effective address, already computed by decode
- req_sdata  in  64  store data (rs)
- req_rt  in  5  target/source GPR
- req_ra  in  5  base GPR for update forms
- mem_valid  out  1  memory request valid
- mem_ready  in  1  memory accepts request
- mem_addr  out  61  doubleword address, ea[0:60]
- mem_we  out  1  store request
- mem_wdata  out  64  store data
- mem_rvalid  in  1  load data valid
- mem_rdata  in  64  load data
- wb_valid  out  1  one-cycle completion pulse
- wb_rt_we  out  1  write rt
- wb_rt  out  5  rt index
- wb_rt_data  out  64  load result
- wb_ra_we  out  1  write ra (update forms)
- wb_ra  out  5  ra index
- wb_ra_data  out  64  ea
- exc_valid  out  1  one-cycle exception pulse
- exc_cause  out  2  1=misaligned, 2=timeout, 3=illegal form or op
- busy  out  1  state is not IDLE

Behaviour:
- All vectors use big-endian numbering: bit 0 is the MSB.
- Reset (async, rst_n low):
  - state goes to IDLE and the timeout counter clears.
  - All outputs are 0 except req_ready=1.
  - mem_valid drops immediately, even mid-transaction; the memory side must tolerate an abandoned request.
- Acceptance:
  - The op is captured on req_valid & req_ready into registers: op, ea, sdata, rt, ra.
  - All later outputs come from these registers only.
- Checks, evaluated on the captured op in the CHECK cycle:
  - Illegal form, cause 3: op 6 or 7; ra==0 on any update form; ra==rt on LDU or LWZU.
  - Misaligned, cause 1: LD/LDU/STD/STDU with ea[61:63]!=0; LWZ/LWZU with ea[62:63]!=0.
  - If both apply, cause 3 takes priority.
- FSM states:
  - IDLE: req_ready=1. Accept moves to CHECK.
  - CHECK: one cycle. Exception: pulse exc_valid, go to IDLE. No memory access occurs and there is no writeback. Otherwise go to REQ.
  - REQ: mem_valid=1 with mem_addr, mem_we and mem_wdata held stable until mem_ready.
    - On a store handshake: go to DONE.
    - On a load handshake: clear the counter, go to WAIT.
  - WAIT: the counter increments each cycle.
    - mem_rvalid captures the data and goes to DONE.
    - When the counter reaches TIMEOUT with no rvalid: pulse exc cause 2, go to DRAIN.
  - DRAIN: req_ready=0. Discard the first mem_rvalid, then go to IDLE. This prevents a stale response being matched to a later load.
  - DONE: pulse wb_valid for one cycle, then go to IDLE.
    - Loads: wb_rt_we=1.
    - Update forms: wb_ra_we=1 and wb_ra_data=ea.
    - STD: wb_valid with both write enables 0.
- Load data:
  - LD: the full mem_rdata.
  - LWZ/LWZU: 32 zero bits concatenated with the selected word. ea[61]=0 selects rdata[0:31]; ea[61]=1 selects rdata[32:63].
- Latency:
  - Store with mem_ready already high: accept to wb_valid is 3 cycles (CHECK, REQ, DONE).
  - Load with rvalid in the cycle after the handshake: 4 cycles.
- The back-to-back accept in IDLE happens the cycle after DONE.
- mem_rvalid outside WAIT and DRAIN is ignored.
- wb_valid and exc_valid are never high together.

Decomposition:
- Shared package ppc_pkg holds:
  - op encodings: LSU_LD..LSU_STDU
  - exc_cause constants: EXC_ALIGN, EXC_TIMEOUT, EXC_FORM
  - the FSM state enum
- One sub-module, ppc_lsu_check: combinational illegal-form and alignment check producing exc and cause. It is reused later by decode for early trap.
- The FSM, counter and datapath stay in ppc_lsu.

Test Plan:
1. LD, ea=0x0000_0000_0000_1000, rt=5; mem_ready=1, rvalid one cycle later with rdata=0x0123456789ABCDEF → mem_addr=0x200; wb_rt_we=1, rt=5, data=0x0123456789ABCDEF, 4 cycles after accept.
2. LWZU, ea=0x...1004, rt=3, ra=4; rdata=0xAAAAAAAA_BBBBBBBB → wb_rt_data=0x00000000BBBBBBBB, wb_ra_we=1, wb_ra=4, wb_ra_data=0x...1004.
3. STDU, ea=0x...0010, ra=0 → exc_valid with cause 3 in the CHECK cycle; mem_valid never asserted.
4. LD with ea=0x...0004 → exc cause 1, no memory request. Then STD to ea=0x...0008 with mem_ready held low 5 cycles → mem_valid stable for 6 cycles, then wb_valid with both write enables 0.
5. TIMEOUT=4: LD handshake, no rvalid → exc cause 2 at the 4th WAIT cycle; req_ready stays 0 until a late rvalid is dropped. The next LD completes with its own data.
6. Assert rst_n low while in WAIT → mem_valid and busy go 0 immediately and req_ready goes 1; an rvalid after release produces no wb_valid.
